// File: rtl/cache_pkg.sv
// Shared types and line geometry for the cache line-fill controller.
package cache_pkg;

  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_IDX_W     = 3;
  localparam int LINE_OFFSET_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } fill_state_e;

  function automatic logic [WORDS_PER_LINE-1:0] word_onehot(
    input logic [WORD_IDX_W-1:0] idx
  );
    word_onehot      = '0;
    word_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Miss, memory-read and cache-write signals of the line-fill controller.
// master = controller side, slave = cache/memory side.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic                                 miss_detected;
  logic [ADDR_W-1:0]                    miss_address;
  logic [DATA_W-1:0]                    memory_data;
  logic                                 memory_data_valid;
  logic                                 fsm_busy;
  logic                                 mem_read;
  logic [ADDR_W-1:0]                    memory_address;
  logic                                 write_data_array;
  logic [cache_pkg::WORDS_PER_LINE-1:0] word_enable;
  logic [DATA_W-1:0]                    data_out;
  logic                                 write_tag_array;

  modport master (
    input  miss_detected,
    input  miss_address,
    input  memory_data,
    input  memory_data_valid,
    output fsm_busy,
    output mem_read,
    output memory_address,
    output write_data_array,
    output word_enable,
    output data_out,
    output write_tag_array
  );

  modport slave (
    output miss_detected,
    output miss_address,
    output memory_data,
    output memory_data_valid,
    input  fsm_busy,
    input  mem_read,
    input  memory_address,
    input  write_data_array,
    input  word_enable,
    input  data_out,
    input  write_tag_array
  );

endinterface

// File: rtl/fill_counter.sv
// 3-bit word counter; done latches when the count wraps past the last word.
module fill_counter
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [WORD_IDX_W-1:0] cnt,
  output logic                  done
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      cnt <= cnt + WORD_IDX_W'(1);
      if (&cnt)
        done <= 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Fills one 8-word cache line from memory after a miss.
// Define CACHE_CWF_EN to fetch the critical (missing) word first.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  cache_fill_ctrl_if.master bus
);

  localparam int TAG_W = ADDR_W - LINE_OFFSET_W;

  fill_state_e           state;
  logic [TAG_W-1:0]      line_tag;
  logic [WORD_IDX_W-1:0] req_cnt;
  logic [WORD_IDX_W-1:0] rx_cnt;
  logic [WORD_IDX_W-1:0] req_idx;
  logic [WORD_IDX_W-1:0] rx_idx;
  logic                  req_done;
  logic                  rx_done;
  logic [WORD_IDX_W:0]   issued;
  logic [WORD_IDX_W:0]   received;
  logic                  cnt_clr;
  logic                  req_en;
  logic                  in_fill;
  logic                  accept;
  logic                  last_req;
  logic                  last_rx;
  logic                  busy_q;
  logic                  rd_q;
  logic                  tag_q;
  logic                  unused_addr;

  assign cnt_clr = (state == IDLE);
  assign req_en  = (state == REQ);
  assign in_fill = (state == REQ) || (state == WAIT);

  fill_counter u_req_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (req_en),
    .cnt  (req_cnt),
    .done (req_done)
  );

  fill_counter u_rx_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (accept),
    .cnt  (rx_cnt),
    .done (rx_done)
  );

`ifdef CACHE_CWF_EN
  logic [WORD_IDX_W-1:0] word_off;

  assign req_idx = word_off + req_cnt;
  assign rx_idx  = word_off + rx_cnt;
`else
  assign req_idx = req_cnt;
  assign rx_idx  = rx_cnt;
`endif

  // The request issued this cycle counts, so zero-latency returns match.
  assign issued   = req_done ? (WORD_IDX_W+1)'(WORDS_PER_LINE)
                             : {1'b0, req_cnt} + {{WORD_IDX_W{1'b0}}, req_en};
  assign received = {rx_done, rx_cnt};
  assign accept   = in_fill && bus.memory_data_valid
                    && (received < issued);
  assign last_req = req_en && (&req_cnt);
  assign last_rx  = accept && (&rx_cnt);

  assign bus.write_data_array = accept;
  assign bus.word_enable      = accept ? word_onehot(rx_idx) : '0;
  assign bus.data_out         = accept ? bus.memory_data
                                       : {DATA_W{1'b0}};
  assign bus.fsm_busy         = busy_q;
  assign bus.mem_read         = rd_q;
  assign bus.write_tag_array  = tag_q;
  assign bus.memory_address   = rd_q ? {line_tag, req_idx, 1'b0}
                                     : '0;

  assign unused_addr = ^bus.miss_address[LINE_OFFSET_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      line_tag <= '0;
      busy_q   <= 1'b0;
      rd_q     <= 1'b0;
      tag_q    <= 1'b0;
`ifdef CACHE_CWF_EN
      word_off <= '0;
`endif
    end else begin
      tag_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.miss_detected) begin
            state    <= REQ;
            line_tag <= bus.miss_address[ADDR_W-1:LINE_OFFSET_W];
            busy_q   <= 1'b1;
            rd_q     <= 1'b1;
`ifdef CACHE_CWF_EN
            word_off <= bus.miss_address[LINE_OFFSET_W-1:1];
`endif
          end
        end
        REQ: begin
          if (last_req)
            rd_q <= 1'b0;
          if (last_rx) begin
            state <= DONE;
            tag_q <= 1'b1;
          end else if (last_req) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (last_rx) begin
            state <= DONE;
            tag_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl with a fixed-latency memory model.
module tb_cache_fill_ctrl;

  localparam int AW = 16;
  localparam int DW = 16;
`ifdef CACHE_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [15:0] addr;
  } req_t;

  typedef struct {
    int          cyc;
    logic [7:0]  we;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) dif ();

  cache_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  req_t  exp_req[$];
  wr_t   exp_wr[$];
  int    exp_tag[$];
  pend_t pend[$];

  int          cyc      = 0;
  int          checks   = 0;
  int          failures = 0;
  int          wr_seen  = 0;
  int          tag_seen = 0;
  int          busy_lo  = 1;
  int          busy_hi  = 0;
  int          lat      = 4;
  logic [15:0] salt     = 16'hA000;
  bit          spur     = 1'b0;
  bit          force_v  = 1'b1;
  bit          extra    = 1'b0;
  int          ret_cnt  = 0;

  req_t  mr;
  wr_t   mw;
  int    mt;
  pend_t rp;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: returns each request lat cycles later, in order.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      pend.delete();
      extra = 1'b0;
    end else if (dif.mem_read) begin
      pend.push_back('{cyc + lat, dif.memory_address});
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      rp = pend.pop_front();
      dif.memory_data_valid = 1'b1;
      dif.memory_data       = salt + 16'(rp.addr[3:1]);
      ret_cnt++;
      extra = spur && (ret_cnt == 8);
    end else if (extra || force_v) begin
      dif.memory_data_valid = 1'b1;
      dif.memory_data       = 16'($urandom);
      extra = 1'b0;
    end else begin
      dif.memory_data_valid = 1'b0;
      dif.memory_data       = 16'($urandom);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs",
          {dif.fsm_busy, dif.mem_read, dif.write_data_array,
           dif.write_tag_array, dif.word_enable,
           |dif.memory_address, |dif.data_out}, 32'd0);
    end else begin
      chk("busy", dif.fsm_busy, (cyc >= busy_lo && cyc <= busy_hi));
      if (dif.mem_read) begin
        if (exp_req.size() == 0) begin
          chk("unexpected_req", dif.memory_address, 32'hFFFF_FFFF);
        end else begin
          mr = exp_req.pop_front();
          chk("req_addr", dif.memory_address, mr.addr);
          chk("req_cycle", cyc, mr.cyc);
        end
      end
      if (dif.write_data_array) begin
        wr_seen++;
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", dif.word_enable, 32'hFFFF_FFFF);
        end else begin
          mw = exp_wr.pop_front();
          chk("word_enable", dif.word_enable, mw.we);
          chk("data_out", dif.data_out, mw.data);
          chk("write_cycle", cyc, mw.cyc);
        end
      end else begin
        chk("we_idle", dif.word_enable, 32'd0);
      end
      if (dif.write_tag_array) begin
        tag_seen++;
        if (exp_tag.size() == 0) begin
          chk("unexpected_tag", cyc, 32'hFFFF_FFFF);
        end else begin
          mt = exp_tag.pop_front();
          chk("tag_cycle", cyc, mt);
        end
      end
    end
  end

  // Drives the miss and records what the line fill must look like.
  task automatic issue_fill(input logic [15:0] addr, input int l,
                            input logic [15:0] s, input bit sp);
    int c, off, w;
    logic [15:0] base;
    @(posedge clk);
    #1;
    lat     = l;
    salt    = s;
    spur    = sp;
    ret_cnt = 0;
    force_v = sp;
    c       = cyc;
    dif.miss_detected = 1'b1;
    dif.miss_address  = addr;
    off  = int'(addr[3:1]);
    base = {addr[15:4], 4'b0000};
    for (int k = 0; k < 8; k++) begin
      w = CWF ? (off + k) % 8 : k;
      exp_req.push_back('{c + 1 + k, base + 16'(2 * w)});
      exp_wr.push_back('{c + 1 + k + l, 8'(1 << w), s + 16'(w)});
    end
    exp_tag.push_back(c + 9 + l);
    busy_lo = c + 1;
    busy_hi = c + 9 + l;
    @(posedge clk);
    #1;
    dif.miss_detected = 1'b0;
    dif.miss_address  = 16'($urandom);
    force_v = 1'b0;
  endtask

  task automatic finish_fill(input int w0, input int t0);
    for (int i = 0; i < 300 && cyc <= busy_hi + 1; i++)
      @(posedge clk);
    if (cyc <= busy_hi + 1)
      chk("fill_timeout", cyc, busy_hi + 2);
    chk("writes_per_fill", wr_seen - w0, 32'd8);
    chk("tags_per_fill", tag_seen - t0, 32'd1);
    chk("left_req", exp_req.size(), 32'd0);
    chk("left_wr", exp_wr.size(), 32'd0);
  endtask

  task automatic do_fill(input logic [15:0] addr, input int l,
                         input logic [15:0] s, input bit sp,
                         input bit midmiss);
    int w0, t0;
    w0 = wr_seen;
    t0 = tag_seen;
    issue_fill(addr, l, s, sp);
    if (midmiss) begin
      repeat (3) @(posedge clk);
      #1;
      dif.miss_detected = 1'b1;
      dif.miss_address  = 16'($urandom);
      @(posedge clk);
      #1;
      dif.miss_detected = 1'b0;
    end
    finish_fill(w0, t0);
  endtask

  task automatic reset_mid(input logic [15:0] addr);
    int w0, t0;
    w0 = wr_seen;
    t0 = tag_seen;
    issue_fill(addr, 4, 16'hC000, 1'b0);
    for (int i = 0; i < 100 && wr_seen < w0 + 3; i++)
      @(posedge clk);
    if (wr_seen < w0 + 3)
      chk("abort_wait_timeout", wr_seen - w0, 32'd3);
    #1;
    rst     = 1'b0;
    force_v = 1'b1;
    exp_req.delete();
    exp_wr.delete();
    exp_tag.delete();
    busy_lo = 1;
    busy_hi = 0;
    #1;
    chk("abort_busy", dif.fsm_busy, 32'd0);
    chk("abort_no_write", dif.write_data_array, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst     = 1'b1;
    force_v = 1'b0;
    repeat (20) @(posedge clk);
    chk("abort_no_tag", tag_seen - t0, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dif.miss_detected = 1'b0;
    dif.miss_address  = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", dif.fsm_busy, 32'd0);
    chk("rst_mem_read", dif.mem_read, 32'd0);
    chk("rst_addr", dif.memory_address, 32'd0);
    chk("rst_wda", dif.write_data_array, 32'd0);
    chk("rst_word_en", dif.word_enable, 32'd0);
    chk("rst_data_out", dif.data_out, 32'd0);
    chk("rst_tag", dif.write_tag_array, 32'd0);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    force_v = 1'b0;
    repeat (3) @(posedge clk);

    do_fill(16'h1236, 4, 16'hA000, 1'b0, 1'b0);
    do_fill(16'h123C, 4, 16'hB000, 1'b0, 1'b0);
    do_fill(16'h5A5A, 4, 16'h3000, 1'b1, 1'b1);
    reset_mid(16'h4442);
    do_fill(16'h4442, 4, 16'hD000, 1'b0, 1'b0);
    do_fill(16'h7F0E, 0, 16'hE000, 1'b0, 1'b0);
    do_fill(16'h7F04, 0, 16'h1100, 1'b1, 1'b1);
    for (int n = 0; n < 8; n++)
      do_fill(16'($urandom), int'($urandom_range(0, 7)),
              16'($urandom), 1'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling controller that fills one 8-word cache line from main memory. It sits between the cache's hit/miss logic and main memory, issues eight sequential word reads, and drives the write side of the cache data array with each returned word. It does this through the per-word data, write-enable and one-hot word-enable signals. It pulses a tag write when the line is complete.

## Interface
- `ADDR_W`, 16, byte address width
- `DATA_W`, 16, word width
- `clk` input 1, sole clock, rising edge
- `rst` input 1, asynchronous, active-low reset
- `miss_detected` input 1, miss request; sampled only in IDLE
- `miss_address` input ADDR_W, byte address of the missing access; sampled with `miss_detected`
- `memory_data` input DATA_W, returned read data
- `memory_data_valid` input 1, `memory_data` valid this cycle
- `fsm_busy` output 1, fill in progress; stalls the pipeline
- `mem_read` output 1, memory read request this cycle
- `memory_address` output ADDR_W, read address, valid while `mem_read`=1
- `write_data_array` output 1, data-array write enable
- `word_enable` output 8, one-hot target word in the line
- `data_out` output DATA_W, word to write (pass-through of `memory_data`)
- `write_tag_array` output 1, one-cycle tag/valid write pulse

## Operation
- **States**
  - IDLE: waiting for a miss.
  - REQ: issuing requests while also accepting returns.
  - WAIT: all requests issued, still accepting returns.
  - DONE: tag write.
- **Counters**: `req_cnt` and `rx_cnt`, both 3-bit, plus `req_done` and `rx_done` flags. Both clear on leaving IDLE.
- **Line base**: `{miss_address[15:4], 4'b0}`, latched on IDLE→REQ. The latched word offset is `miss_address[3:1]`.
- **IDLE→REQ**: on `miss_detected`=1.
- **REQ**
  - `mem_read`=1 every cycle.
  - `memory_address` = base + 2·`req_idx`.
  - `req_cnt` increments each cycle.
  - Exits to WAIT after the 8th request.
- **Accepting returns (REQ or WAIT)**: a return with `memory_data_valid`=1 is accepted only if `rx_cnt` < issued count.
  - The same cycle drives `write_data_array`=1, `word_enable`=1<<`rx_idx`, `data_out`=`memory_data`.
  - `rx_cnt` increments.
- **WAIT→DONE**: when the 8th return is accepted (this can happen directly from REQ if the memory latency is 0).
- **DONE→IDLE**: after one cycle with `write_tag_array`=1.
- **Ignored inputs**
  - `memory_data_valid` in IDLE or DONE, or any excess valid: no write.
  - `miss_detected` while busy.
- **Combinational outputs**: `write_data_array`, `word_enable` and `data_out` are combinational from `memory_data_valid`/`memory_data` and state. `word_enable` is all-zero whenever `write_data_array`=0.
- **Memory ordering**: memory returns words in request order.

## Timing
- **Reset**: all outputs 0, state IDLE, counters 0. Assertion mid-fill aborts immediately: no partial tag write, and no write-enable while `rst`=0.
- **Miss sampling**: `miss_detected` sampled at edge N → `fsm_busy`=1 and first `mem_read` in cycle N+1. Requests occupy cycles N+1..N+8.
- **Return path**: each accepted valid writes in the same cycle (zero latency).
- **Completion**: 8th valid at cycle M → DONE in M+1 (`write_tag_array`=1, `fsm_busy`=1) → IDLE in M+2 (`fsm_busy`=0). A new miss is accepted from M+2.
- **Fixed 4-cycle memory**: words return in cycles N+5..N+12 and `fsm_busy` is high for 13 cycles.
- **Simultaneous events**: a valid arriving in the same cycle as the 8th request is accepted normally.

## Configuration
- **`CACHE_CWF_EN` defined** (critical word first): `req_idx` = (offset + `req_cnt`) mod 8 and `rx_idx` = (offset + `rx_cnt`) mod 8, wrapping 7→0. The missing word is fetched and written first.
- **`CACHE_CWF_EN` undefined**: `req_idx`=`req_cnt` and `rx_idx`=`rx_cnt`, so words 0..7 are fetched in order and the offset is unused.

## Structure
- **Package `cache_pkg`**: state enum (IDLE/REQ/WAIT/DONE), `WORDS_PER_LINE`=8, `WORD_IDX_W`=3, `LINE_OFFSET_W`=4.
- **Sub-module `fill_counter`**: 3-bit counter with enable, synchronous clear, async active-low reset and a wrap/done flag. It is instantiated twice, once for requests and once for returns.

## Test plan
- **Reset**: hold `rst`=0 with `memory_data_valid`=1 → all outputs 0, including `word_enable`=8'h00.
- **Basic fill, CWF off**: miss at 16'h1236 with 4-cycle memory returning 16'hA000+i → addresses 16'h1230..16'h123E. Word i is written with `word_enable`=1<<i; `write_tag_array` pulses in cycle N+13; busy lasts 13 cycles.
- **CWF on**: miss at 16'h123C (offset 6) → request order 16'h123C, 16'h123E, 16'h1230…16'h123A. The first write has `word_enable`=8'h40; the third (wrap) has 8'h01.
- **Spurious and ignored inputs**: valid in IDLE, a 9th valid after 8 accepted, and `miss_detected` pulsed mid-fill → none causes a write or restart. Exactly 8 writes and 1 tag pulse occur.
- **Reset mid-fill**: `rst` low after the 3rd return → outputs 0 immediately, no tag pulse. A new miss afterwards completes a full fill from word 0.
- **Zero-latency memory**: valid in the same cycle as each `mem_read` → eight consecutive writes, DONE in cycle N+9.
